sw_input_debounce: RTL and testbench
====================================

// Module: sw_input_debounce
// PURPOSE
// Conditions the raw board switches before they reach the load/store unit's
// input-peripheral word (io_sw_i).
// - Per-bit 2-flop synchroniser, then a per-bit debounce counter.
// - Presents a clean, zero-extended 32-bit switch word to the LSU.
// - Latches qualified switch edges into per-bit pending flags and raises a
//   level interrupt request toward the interrupt handler.
// PARAMETERS
// N_SW             18   number of switch bits, 1..32
// DEBOUNCE_CYCLES  16   consecutive differing cycles needed to accept a change, >=1
// CNT_W            $clog2(DEBOUNCE_CYCLES+1)   debounce counter width (derived)
// PORTS
// clk_i           in   1      system clock
// rst_i           in   1      synchronous, active-high reset
// sw_raw_i        in   N_SW   raw switches, asynchronous to clk_i
// edge_sel_i      in   2      00 rising, 01 falling, 10 both, 11 none
// irq_en_i        in   N_SW   per-bit interrupt enable
// irq_clr_i       in   1      clear strobe for pending flags
// irq_clr_mask_i  in   N_SW   bits cleared when irq_clr_i=1
// io_sw_o         out  32     {zeros, stable_q}; drives LSU io_sw_i
// sw_pending_o    out  N_SW   latched edge flags
// irq_o           out  1      |(sw_pending_o & irq_en_i), combinational from regs
// BEHAVIOUR
// - Reset (rst_i=1 at a rising edge):
//   - Clears sync1, sync2, stable_q, all counters and pending.
//   - Outputs read 0 on the following cycle.
//   - Mid-count progress is discarded.
// - Synchroniser: sync1<=sw_raw_i; sync2<=sync1.
// - Debounce, per bit b:
//   - If sync2[b]==stable_q[b]: cnt[b]<=0.
//   - Else if cnt[b]==DEBOUNCE_CYCLES-1: stable_q[b]<=sync2[b], cnt[b]<=0,
//     commit[b]=1.
//   - Else: cnt[b]<=cnt[b]+1.
// - Latency: a raw change held steady appears on io_sw_o after the
//   (DEBOUNCE_CYCLES+2)th rising edge, counting the first sampling edge as 1.
// - Glitch rejection: any return to the stable value before the count
//   completes resets cnt[b]. No output change and no event result.
// - Event generation:
//   - event[b] = commit[b] & selected polarity.
//   - Rising means new value 1; falling means new value 0.
//   - edge_sel_i is sampled in the commit cycle.
//   - edge_sel_i=11 never produces an event, but io_sw_o still updates.
// - Pending update:
//   - pending[b] <= (pending[b] & ~(irq_clr_i & irq_clr_mask_i[b])) | event[b].
//   - A new event wins over a same-cycle clear of the same bit.
//   - Clearing one bit does not disturb other bits.
// - irq_o:
//   - Level output; stays high until every enabled pending bit is cleared.
//   - irq_en_i masks irq_o only; pending still latches while disabled.
// - After reset with a switch already high: after D+2 edges stable_q goes
//   to 1 and generates a rising event (stable_q resets to 0).
// - Bits N_SW..31 of io_sw_o are always 0.
// - No combinational path from sw_raw_i to any output.
// TESTING (N_SW=18, DEBOUNCE_CYCLES=4, edge_sel_i=00 unless stated)
// 1. Reset, then sw_raw_i=18'h00001 held, irq_en_i[0]=1
//    -> io_sw_o=32'h0 after edge 5; io_sw_o=32'h1, sw_pending_o[0]=1 and
//       irq_o=1 after edge 6.
// 2. sw_raw_i[3] high for 3 cycles, then low
//    -> io_sw_o stays 32'h0; sw_pending_o=0; irq_o=0.
// 3. edge_sel_i=01, bit0 debounced 0->1->0
//    -> no pending on the rise; sw_pending_o[0]=1 only after the fall commits.
// 4. irq_clr_i=1, irq_clr_mask_i=18'h3 in the same cycle as a bit0 commit,
//    with pending=18'h2
//    -> pending=18'h1 next cycle (bit1 cleared, bit0 set wins).
// 5. rst_i pulsed while bit2 has cnt=3
//    -> all outputs 0; after release, bit2 needs 6 more edges to show on io_sw_o.
// 6. edge_sel_i=11 with bit5 toggling -> io_sw_o tracks after 6 edges,
//    pending=0. Then edge_sel_i=00 with irq_en_i=0 -> pending[5]=1, irq_o=0;
//    setting irq_en_i[5]=1 -> irq_o=1.

Source files
------------

// File: rtl/sw_input_debounce.sv
// Switch conditioner: per-bit 2-flop synchroniser, debounce counter, edge
// capture into pending flags and a level interrupt request.
module sw_input_debounce #(
  parameter int N_SW            = 18,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_SW-1:0]   sw_raw_i,
  input  logic [1:0]        edge_sel_i,
  input  logic [N_SW-1:0]   irq_en_i,
  input  logic              irq_clr_i,
  input  logic [N_SW-1:0]   irq_clr_mask_i,
  output logic [31:0]       io_sw_o,
  output logic [N_SW-1:0]   sw_pending_o,
  output logic              irq_o
);

  localparam int unsigned NB = N_SW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync1_q;
  logic [N_SW-1:0]  sync2_q;
  logic [N_SW-1:0]  stable_q;
  logic [N_SW-1:0]  pending_q;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [N_SW-1:0]  commit;
  logic [N_SW-1:0]  evt;

  // A commit happens when the synchronised value has differed for the full count;
  // the event polarity is judged against the value being committed.
  always_comb begin
    commit = '0;
    evt    = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if ((sync2_q[b] != stable_q[b]) && (cnt_q[b] == CNT_MAX)) begin
        commit[b] = 1'b1;
        case (edge_sel_i)
          2'b00:   evt[b] = sync2_q[b];
          2'b01:   evt[b] = ~sync2_q[b];
          2'b10:   evt[b] = 1'b1;
          default: evt[b] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      for (int unsigned b = 0; b < NB; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
      for (int unsigned b = 0; b < NB; b++) begin
        if (sync2_q[b] == stable_q[b]) begin
          cnt_q[b] <= '0;
        end else if (commit[b]) begin
          stable_q[b] <= sync2_q[b];
          cnt_q[b]    <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
      end
      // OR-ing the event last lets a new edge win over a same-cycle clear.
      pending_q <= (pending_q & ~({N_SW{irq_clr_i}} & irq_clr_mask_i)) | evt;
    end
  end

  assign io_sw_o      = 32'(stable_q);
  assign sw_pending_o = pending_q;
  assign irq_o        = |(pending_q & irq_en_i);

endmodule

// File: tb/tb_sw_input_debounce.sv
// Directed self-checking bench for sw_input_debounce (N_SW=18, DEBOUNCE_CYCLES=4).
module tb_sw_input_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw_raw;
  logic [1:0]  edge_sel;
  logic [17:0] irq_en;
  logic        irq_clr;
  logic [17:0] irq_clr_mask;
  logic [31:0] io_sw;
  logic [17:0] pending;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  sw_input_debounce #(.N_SW(18), .DEBOUNCE_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sw_raw_i       (sw_raw),
    .edge_sel_i     (edge_sel),
    .irq_en_i       (irq_en),
    .irq_clr_i      (irq_clr),
    .irq_clr_mask_i (irq_clr_mask),
    .io_sw_o        (io_sw),
    .sw_pending_o   (pending),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw_raw = '0; edge_sel = 2'b00; irq_en = '0;
    irq_clr = 1'b0; irq_clr_mask = '0;
    tick(2);
    rst = 1'b0;
    chk("reset_io_sw", io_sw, 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // 1: rise on bit0, visible after edge 6
    irq_en = 18'h00001; sw_raw = 18'h00001;
    tick(5);
    chk("t1_io_sw_edge5", io_sw, 32'h0);
    chk("t1_pending_edge5", 32'(pending), 32'h0);
    tick(1);
    chk("t1_io_sw_edge6", io_sw, 32'h1);
    chk("t1_pending_edge6", 32'(pending), 32'h1);
    chk("t1_irq_edge6", 32'(irq), 32'h1);
    irq_clr = 1'b1; irq_clr_mask = 18'h00001;
    tick(1);
    irq_clr = 1'b0;
    chk("t1_clear_pending", 32'(pending), 32'h0);
    chk("t1_clear_irq", 32'(irq), 32'h0);

    // 2: bit3 glitch of 3 cycles is rejected
    sw_raw = 18'h00009;
    tick(3);
    sw_raw = 18'h00001;
    tick(8);
    chk("t2_io_sw", io_sw, 32'h1);
    chk("t2_pending", 32'(pending), 32'h0);
    chk("t2_irq", 32'(irq), 32'h0);

    // 3: falling-only selection
    sw_raw = 18'h00000;
    tick(6);
    chk("t3_fall_rising_sel_io", io_sw, 32'h0);
    chk("t3_fall_rising_sel_pend", 32'(pending), 32'h0);
    edge_sel = 2'b01; sw_raw = 18'h00001;
    tick(6);
    chk("t3_rise_io", io_sw, 32'h1);
    chk("t3_rise_pending", 32'(pending), 32'h0);
    sw_raw = 18'h00000;
    tick(5);
    chk("t3_fall_edge5_io", io_sw, 32'h1);
    chk("t3_fall_edge5_pend", 32'(pending), 32'h0);
    tick(1);
    chk("t3_fall_io", io_sw, 32'h0);
    chk("t3_fall_pending", 32'(pending), 32'h1);
    chk("t3_fall_irq", 32'(irq), 32'h1);

    // 4: event wins over a same-cycle clear
    edge_sel = 2'b00; irq_clr = 1'b1; irq_clr_mask = 18'h00001;
    tick(1);
    irq_clr = 1'b0;
    sw_raw = 18'h00002;
    tick(6);
    chk("t4_setup_io", io_sw, 32'h2);
    chk("t4_setup_pending", 32'(pending), 32'h2);
    sw_raw = 18'h00003;
    tick(5);
    irq_clr = 1'b1; irq_clr_mask = 18'h00003;
    tick(1);
    irq_clr = 1'b0;
    chk("t4_pending", 32'(pending), 32'h1);
    chk("t4_io_sw", io_sw, 32'h3);

    // 5: reset discards mid-count progress on bit2
    sw_raw = 18'h00007;
    tick(5);
    chk("t5_pre_reset_io", io_sw, 32'h3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_reset_io", io_sw, 32'h0);
    chk("t5_reset_pending", 32'(pending), 32'h0);
    chk("t5_reset_irq", 32'(irq), 32'h0);
    tick(5);
    chk("t5_edge5_io", io_sw, 32'h0);
    tick(1);
    chk("t5_edge6_io", io_sw, 32'h7);
    chk("t5_edge6_pending", 32'(pending), 32'h7);
    chk("t5_edge6_irq", 32'(irq), 32'h1);
    irq_clr = 1'b1; irq_clr_mask = 18'h00002;
    tick(1);
    irq_clr = 1'b0;
    chk("t5_partial_clear", 32'(pending), 32'h5);

    // 6: no-event selection, then masked interrupt
    irq_clr = 1'b1; irq_clr_mask = '1;
    tick(1);
    irq_clr = 1'b0;
    chk("t6_clear_all", 32'(pending), 32'h0);
    edge_sel = 2'b11; sw_raw = 18'h00027;
    tick(6);
    chk("t6_none_rise_io", io_sw, 32'h27);
    chk("t6_none_rise_pend", 32'(pending), 32'h0);
    sw_raw = 18'h00007;
    tick(6);
    chk("t6_none_fall_io", io_sw, 32'h7);
    chk("t6_none_fall_pend", 32'(pending), 32'h0);
    edge_sel = 2'b00; irq_en = '0; sw_raw = 18'h00027;
    tick(6);
    chk("t6_masked_pending", 32'(pending), 32'h20);
    chk("t6_masked_irq", 32'(irq), 32'h0);
    irq_en = 18'h00020;
    #1;
    chk("t6_enabled_irq", 32'(irq), 32'h1);

    // upper bits stay zero with every switch high
    sw_raw = '1;
    tick(6);
    chk("all_high_io", io_sw, 32'h0003FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
